// File: rtl/sha2_chunk_engine_if.sv
// Start/busy/done bus between the message padder and the SHA-2 chunk engine.
// Carries the chunk, the base hash and the resulting digest.
interface sha2_chunk_engine_if #(
    parameter int WORD_W = 64
);
    logic                  start;
    logic                  chain;
    logic [16*WORD_W-1:0]  chunk;
    logic [8*WORD_W-1:0]   h_in;
    logic                  busy;
    logic                  done;
    logic [8*WORD_W-1:0]   h_out;

    modport master (
        output start, chain, chunk, h_in,
        input  busy, done, h_out
    );

    modport slave (
        input  start, chain, chunk, h_in,
        output busy, done, h_out
    );
endinterface

// File: rtl/sha2_chunk_engine.sv
// SHA-256/512 compression of one chunk with a rolling 16-word schedule.
// Define SHA2_TWO_ROUNDS_EN to run two chained rounds per cycle.
module sha2_chunk_engine #(
    parameter int WORD_W = 64
) (
    input  logic            clk,
    input  logic            reset,
    sha2_chunk_engine_if.slave bus
);
    localparam bit W64 = (WORD_W == 64);
    localparam int ROUNDS = W64 ? 80 : 64;
`ifdef SHA2_TWO_ROUNDS_EN
    localparam logic [6:0] STEP = 7'd2;
`else
    localparam logic [6:0] STEP = 7'd1;
`endif

    localparam int B0A = W64 ? 28 : 2;
    localparam int B0B = W64 ? 34 : 13;
    localparam int B0C = W64 ? 39 : 22;
    localparam int B1A = W64 ? 14 : 6;
    localparam int B1B = W64 ? 18 : 11;
    localparam int B1C = W64 ? 41 : 25;
    localparam int S0A = W64 ? 1  : 7;
    localparam int S0B = W64 ? 8  : 18;
    localparam int S0C = W64 ? 7  : 3;
    localparam int S1A = W64 ? 19 : 17;
    localparam int S1B = W64 ? 61 : 19;
    localparam int S1C = W64 ? 6  : 10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_chunk_engine: WORD_W must be 32 or 64");
    end

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [7:0][WORD_W-1:0] st_t;
    typedef logic [15:0][WORD_W-1:0] sch_t;

    // SHA-256 constants are the upper halves of the first 64 SHA-512 ones
    localparam logic [63:0] KT [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic word_t kw(input logic [6:0] i);
        kw = KT[i][63 -: WORD_W];
    endfunction

    function automatic word_t rotr(input word_t x, input int n);
        rotr = (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic sch_t shift(input sch_t s);
        word_t s0, s1;
        s0 = rotr(s[1], S0A) ^ rotr(s[1], S0B) ^ (s[1] >> S0C);
        s1 = rotr(s[14], S1A) ^ rotr(s[14], S1B) ^ (s[14] >> S1C);
        shift = {s1 + s[9] + s0 + s[0], s[15:1]};
    endfunction

    // Index 0 is a, index 7 is h
    function automatic st_t rnd(input st_t s, input word_t k, input word_t w);
        word_t t1, t2, e1, a0;
        e1 = rotr(s[4], B1A) ^ rotr(s[4], B1B) ^ rotr(s[4], B1C);
        a0 = rotr(s[0], B0A) ^ rotr(s[0], B0B) ^ rotr(s[0], B0C);
        t1 = s[7] + e1 + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
        t2 = a0 + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
        rnd = {s[6:0], t1 + t2};
        rnd[4] = s[3] + t1;
    endfunction

    logic [2:0]          state_q, state_d;
    logic [6:0]          t_q, t_d;
    sch_t                sched_q, sched_d, sched_n;
    st_t                 h_q, h_d, wk_q, wk_d, wk_n;
    logic [8*WORD_W-1:0] hout_q, hout_d;

    always_comb begin
`ifdef SHA2_TWO_ROUNDS_EN
        wk_n    = rnd(rnd(wk_q, kw(t_q), sched_q[0]), kw(t_q + 7'd1), sched_q[1]);
        sched_n = shift(shift(sched_q));
`else
        wk_n    = rnd(wk_q, kw(t_q), sched_q[0]);
        sched_n = shift(sched_q);
`endif
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        sched_d = sched_q;
        h_d     = h_q;
        wk_d    = wk_q;
        hout_d  = hout_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    for (int i = 0; i < 16; i++)
                        sched_d[i] = bus.chunk[(15-i)*WORD_W +: WORD_W];
                    for (int i = 0; i < 8; i++)
                        h_d[i] = bus.chain ? hout_q[(7-i)*WORD_W +: WORD_W]
                                           : bus.h_in[(7-i)*WORD_W +: WORD_W];
                end
            end
            S_LOAD: begin
                wk_d    = h_q;
                t_d     = '0;
                state_d = S_ROUND;
            end
            // Counter reaching ROUNDS marks the schedule exhausted
            S_ROUND: begin
                if (t_q == 7'(ROUNDS)) begin
                    state_d = S_FINAL;
                end else begin
                    wk_d    = wk_n;
                    sched_d = sched_n;
                    t_d     = t_q + STEP;
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 8; i++)
                    hout_d[(7-i)*WORD_W +: WORD_W] = h_q[i] + wk_q[i];
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            sched_q <= '0;
            h_q     <= '0;
            wk_q    <= '0;
            hout_q  <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            sched_q <= sched_d;
            h_q     <= h_d;
            wk_q    <= wk_d;
            hout_q  <= hout_d;
        end
    end

    assign bus.busy  = (state_q == S_LOAD) || (state_q == S_ROUND) ||
                       (state_q == S_FINAL);
    assign bus.done  = (state_q == S_DONE);
    assign bus.h_out = hout_q;
endmodule

// File: tb/tb_sha2_chunk_engine.sv
// Scoreboard bench for sha2_chunk_engine with SHA-256 and SHA-512 instances.
// Honours SHA2_TWO_ROUNDS_EN for the expected latencies.
module tb_sha2_chunk_engine;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha2_chunk_engine_if #(.WORD_W(32)) b32 ();
    sha2_chunk_engine_if #(.WORD_W(64)) b64 ();

    sha2_chunk_engine #(.WORD_W(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
    sha2_chunk_engine #(.WORD_W(64)) u64 (.clk(clk), .reset(reset), .bus(b64));

`ifdef SHA2_TWO_ROUNDS_EN
    localparam int L32 = 35;
    localparam int L64 = 43;
`else
    localparam int L32 = 67;
    localparam int L64 = 83;
`endif

    typedef struct {
        logic [511:0] dig;
        bit           cd;
        int           st;
        int           lat;
        string        nm;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    localparam logic [255:0] IV256 =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b,
        64'ha54ff53a5f1d36f1, 64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0] ABC_CK256 = {32'h61626380, 448'h0, 32'h18};
    localparam logic [1023:0] ABC_CK512 = {32'h61626380, 928'h0, 64'h18};
    localparam logic [255:0] DIG256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] DIG512 = {
        64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2,
        64'h0a9eeee64b55d39a, 64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd,
        64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
    localparam logic [511:0] DIG896 = {
        64'h8e959b75dae313da, 64'h8cf4f72814fc143f, 64'h8f7779c6eb9f7fa1,
        64'h7299aeadb6889018, 64'h501d289e4900f7e4, 64'h331b99dec4b5433a,
        64'hc7d329eeb6dd2654, 64'h5e96e55b874be909};

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic bad(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", nm);
    endtask

    bit prev32, prev64;
    exp_t e32, e64;

    always @(negedge clk) begin
        if (!reset) begin
            prev32 = 1'b0;
        end else begin
            if (b32.done && !prev32) begin
                if (q32.size() == 0) bad("unexpected_done32");
                else begin
                    e32 = q32.pop_front();
                    if (e32.cd) chk({e32.nm, "_digest"}, {256'h0, b32.h_out}, e32.dig);
                    chk({e32.nm, "_latency"}, 512'(cyc - e32.st), 512'(e32.lat));
                end
            end
            prev32 = b32.done;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            prev64 = 1'b0;
        end else begin
            if (b64.done && !prev64) begin
                if (q64.size() == 0) bad("unexpected_done64");
                else begin
                    e64 = q64.pop_front();
                    if (e64.cd) chk({e64.nm, "_digest"}, b64.h_out, e64.dig);
                    chk({e64.nm, "_latency"}, 512'(cyc - e64.st), 512'(e64.lat));
                end
            end
            prev64 = b64.done;
        end
    end

    // Called at a negedge; the following posedge samples start
    task automatic go(input bit w64, input string nm, input logic [1023:0] ck,
                      input logic [511:0] hi, input bit ch,
                      input logic [511:0] dig, input bit cd);
        exp_t e;
        e.dig = dig;
        e.cd  = cd;
        e.st  = cyc + 1;
        e.lat = w64 ? L64 : L32;
        e.nm  = nm;
        if (w64) begin
            b64.chunk = ck;
            b64.h_in  = hi;
            b64.chain = ch;
            b64.start = 1'b1;
            q64.push_back(e);
        end else begin
            b32.chunk = ck[511:0];
            b32.h_in  = hi[255:0];
            b32.chain = ch;
            b32.start = 1'b1;
            q32.push_back(e);
        end
        @(negedge clk);
        b32.start = 1'b0;
        b64.start = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q32.size() != 0 || q64.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        if (q32.size() != 0 || q64.size() != 0) begin
            bad({nm, "_timeout"});
            q32.delete();
            q64.delete();
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_busy32"}, 512'(b32.busy), 512'(0));
        chk({nm, "_done32"}, 512'(b32.done), 512'(0));
        chk({nm, "_hout32"}, {256'h0, b32.h_out}, 512'h0);
        chk({nm, "_busy64"}, 512'(b64.busy), 512'(0));
        chk({nm, "_done64"}, 512'(b64.done), 512'(0));
        chk({nm, "_hout64"}, b64.h_out, 512'h0);
    endtask

    logic [895:0]  msg;
    logic [1023:0] blk1, blk2;

    initial begin
        msg = "abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu";
        blk1 = {msg, 8'h80, 120'h0};
        blk2 = 1024'h380;
        reset = 1'b0;
        b32.start = 1'b0; b32.chain = 1'b0; b32.chunk = '0; b32.h_in = '0;
        b64.start = 1'b0; b64.chain = 1'b0; b64.chunk = '0; b64.h_in = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Both widths on "abc" in parallel
        go(1'b0, "abc256", {512'h0, ABC_CK256}, {256'h0, IV256}, 1'b0,
           {256'h0, DIG256}, 1'b1);
        go(1'b1, "abc512", ABC_CK512, IV512, 1'b0, DIG512, 1'b1);
        drain("abc");

        // Two-block message: second block chains on the first result
        go(1'b1, "blk1", blk1, IV512, 1'b0, 512'h0, 1'b0);
        drain("blk1");
        go(1'b1, "blk2", blk2, 512'h0, 1'b1, DIG896, 1'b1);
        drain("blk2");

        // Start pulses while busy must be ignored
        go(1'b1, "busy_start", ABC_CK512, IV512, 1'b0, DIG512, 1'b1);
        repeat (3) @(negedge clk);
        b64.chunk = blk1;
        b64.start = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
        repeat (34) @(negedge clk);
        b64.start = 1'b1;
        @(negedge clk);
        b64.start = 1'b0;
        drain("busy_start");
        repeat (20) @(negedge clk);

        // Abort a SHA-256 run around round 30
        go(1'b0, "aborted", {512'h0, ABC_CK256}, {256'h0, IV256}, 1'b0,
           {256'h0, DIG256}, 1'b1);
        repeat (31) @(negedge clk);
        #2 reset = 1'b0;
        q32.delete();
        #1 chk_zero("abort");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        go(1'b0, "rerun256", {512'h0, ABC_CK256}, {256'h0, IV256}, 1'b0,
           {256'h0, DIG256}, 1'b1);
        go(1'b1, "rerun512", ABC_CK512, IV512, 1'b0, DIG512, 1'b1);
        drain("rerun");
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sha2_chunk_engine.md
Name: sha2_chunk_engine

Overview:
- Parametrised SHA-2 compression engine: processes one 16-word message chunk against an 8-word chaining state.
- Supports SHA-256 (WORD_W=32, 64 rounds) and SHA-512 (WORD_W=64, 80 rounds).
- Uses a rolling 16-entry message schedule instead of a full W array.
- Adds a start/busy/done handshake and multi-chunk chaining. Sits between the message padder and the digest output stage.

Parameters:
WORD_W, 64, word width; legal values 32 (SHA-256) or 64 (SHA-512); any other value is an elaboration error
ROUNDS, derived, 64 when WORD_W=32, 80 when WORD_W=64; localparam, not overridable

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE or DONE
chain  input  1  sampled with start; 1 = initial state is current h_out, 0 = initial state is h_in
chunk  input  16*WORD_W  message chunk, big-endian: word 0 = chunk[16*WORD_W-1 -: WORD_W]
h_in  input  8*WORD_W  initial hash H0..H7, H0 in the MSBs
busy  output  1  high from the cycle after start is accepted until done rises
done  output  1  high in DONE state; h_out valid while high
h_out  output  8*WORD_W  resulting hash H0..H7, H0 in the MSBs

Behaviour:
- States: IDLE, LOAD, ROUND, FINAL, DONE; encoding is free.
- Reset (asynchronous, active-low): state=IDLE, busy=0, done=0, h_out=0, round counter=0, schedule/working registers=0. Reset mid-operation aborts immediately; no partial result is retained.
- IDLE/DONE with start=1 -> LOAD. The engine captures chunk into the 16-entry schedule shift register, and captures the base state (h_in, or h_out if chain=1) into the H registers. done drops on the next edge.
- start=0 in DONE: stay in DONE; h_out and done are held.
- LOAD -> ROUND: working registers a..h are loaded from the H registers; round counter t=0.
- ROUND, one round per cycle:
  - Current word is sched[0].
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + sched[0]; T2 = Σ0(a) + Maj(a,b,c); a..h update per FIPS 180-4.
  - Schedule shifts by one; new sched[15] = σ1(sched[14]) + sched[9] + σ0(sched[1]) + sched[0].
  - All additions are mod 2^WORD_W.
  - t increments; after round t=ROUNDS-1 -> FINAL.
- Rotation/shift amounts:
  - WORD_W=32: Σ0 2/13/22, Σ1 6/11/25, σ0 7/18/>>3, σ1 17/19/>>10.
  - WORD_W=64: Σ0 28/34/39, Σ1 14/18/41, σ0 1/8/>>7, σ1 19/61/>>6.
- K table: 64 SHA-256 constants or 80 SHA-512 constants, selected at elaboration.
- FINAL: h_out word i = H[i] + working[i] (mod 2^WORD_W) -> DONE.
- Latency: done rises exactly ROUNDS+3 clock edges after the edge that samples start (LOAD, ROUNDS×ROUND, FINAL, DONE). That is 67 edges for SHA-256 and 83 for SHA-512.
- start while busy: ignored; no queueing.
- chain=1 with no prior result: uses h_out as is (0 after reset); this is legal.
- h_out changes only at FINAL; it is stable through DONE and IDLE, including across the next LOAD/ROUND.
- chunk and h_in need only be valid on the cycle start is accepted.

Optional Feature:
- Macro SHA2_TWO_ROUNDS_EN.
- Defined:
  - ROUND performs two chained rounds per cycle, consuming sched[0] and sched[1].
  - Schedule shifts by two, generating two new words; the second uses the first.
  - t increments by 2; latency = ROUNDS/2+3 (35 for SHA-256, 43 for SHA-512).
- Undefined: one round per cycle as above.
- Results must be bit-identical in both builds.

Test Plan:
- WORD_W=32, chain=0, h_in=SHA-256 IV, chunk="abc" padded (0x61626380, zeros, last word 0x00000018) -> h_out=ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; done at edge 67 after start.
- WORD_W=64, chain=0, h_in=SHA-512 IV, chunk="abc" padded (last word 0x18) -> h_out=ddaf35a1...a54ca49f (FIPS 180-4 vector); done at edge 83.
- WORD_W=64, two-block message "abcdefghbcdefghi...nopqrstu" (FIPS 896-bit vector): block 1 chain=0 with IV, block 2 chain=1 -> h_out=8e959b75...874be909.
- Pulse start again at cycles 5 and 40 while busy -> no restart; h_out and done timing identical to a single start.
- Assert reset at round 30, release, then rerun the "abc" case -> immediately after reset busy=0, done=0, h_out=0; rerun gives the correct digest.
- Build with SHA2_TWO_ROUNDS_EN, repeat the first two scenarios -> same digests; done at edges 35 and 43.
